// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: sequences R-type/ADDI/SLTI/LW/SW/BEQ/J with a mem_ready handshake.
// Optional bus-timeout exception is built when MC_CTRL_TIMEOUT_EN is defined.
module mc_control_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 5,
   parameter int unsigned CAUSE_W        = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_read,
   output logic               mem_write,
   output logic               i_or_d,
   output logic               ir_write,
   output logic               pc_en,
   output logic [1:0]         pc_source,
   output logic [1:0]         alu_op,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               epc_write,
   output logic               cause_write,
   output logic [CAUSE_W-1:0] cause,
   output logic               instr_done,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StExcept = 4'd10
   } state_t;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;

   typedef struct packed {
      logic               mem_read;
      logic               mem_write;
      logic               i_or_d;
      logic               ir_write;
      logic               pc_en;
      logic [1:0]         pc_source;
      logic [1:0]         alu_op;
      logic               alu_src_a;
      logic [1:0]         alu_src_b;
      logic               reg_write;
      logic               reg_dst;
      logic               mem_to_reg;
      logic               epc_write;
      logic               cause_write;
      logic [CAUSE_W-1:0] cause;
      logic               instr_done;
      logic [3:0]         state;
   } ctrl_t;

   if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
   end

   state_t             state_q, state_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic               pc_write, pc_write_cond;
   logic               timeout;
   ctrl_t              ctl, ctl_g;

`ifdef MC_CTRL_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             waiting;

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
      cnt_d   = cnt_q;
      if (state_d != state_q)          cnt_d = '0;
      else if (waiting && !mem_ready)  cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cause_d       = cause_q;
      ctl           = '0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      unique case (state_q)
         StFetch: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = 2'b01;
            if (mem_ready) begin
               ctl.ir_write = 1'b1;
               pc_write     = 1'b1;
               state_d      = StDecode;
            end else if (timeout) begin
               state_d = StExcept;
               cause_d = CAUSE_W'(1);
            end
         end
         StDecode: begin
            // Branch target precomputed into ALUOut
            ctl.alu_src_b = 2'b11;
            unique case (opcode)
               OpRtype, OpAddi, OpSlti: state_d = StExec;
               OpLw, OpSw:              state_d = StMemAdr;
               OpBeq:                   state_d = StBranch;
               OpJ:                     state_d = StJump;
               default: begin
                  state_d = StExcept;
                  cause_d = '0;
               end
            endcase
         end
         StMemAdr: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            state_d       = (opcode == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            ctl.mem_read = 1'b1;
            ctl.i_or_d   = 1'b1;
            if (mem_ready) begin
               state_d = StMemWb;
            end else if (timeout) begin
               state_d = StExcept;
               cause_d = CAUSE_W'(1);
            end
         end
         StMemWb: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = StFetch;
         end
         StMemWr: begin
            ctl.mem_write = 1'b1;
            ctl.i_or_d    = 1'b1;
            if (mem_ready) begin
               ctl.instr_done = 1'b1;
               state_d        = StFetch;
            end else if (timeout) begin
               state_d = StExcept;
               cause_d = CAUSE_W'(1);
            end
         end
         StExec: begin
            ctl.alu_src_a = 1'b1;
            state_d       = StAluWb;
            case (opcode)
               OpRtype: begin
                  ctl.alu_src_b = 2'b00;
                  ctl.alu_op    = 2'b10;
               end
               OpSlti: begin
                  ctl.alu_src_b = 2'b10;
                  ctl.alu_op    = 2'b11;
               end
               default: begin
                  ctl.alu_src_b = 2'b10;
                  ctl.alu_op    = 2'b00;
               end
            endcase
         end
         StAluWb: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = (opcode == OpRtype);
            ctl.instr_done = 1'b1;
            state_d        = StFetch;
         end
         StBranch: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_op     = 2'b01;
            ctl.pc_source  = 2'b01;
            pc_write_cond  = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = StFetch;
         end
         StJump: begin
            ctl.pc_source  = 2'b10;
            pc_write       = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = StFetch;
         end
         StExcept: begin
            ctl.epc_write   = 1'b1;
            ctl.cause_write = 1'b1;
            ctl.pc_source   = 2'b11;
            ctl.cause       = cause_q;
            pc_write        = 1'b1;
            state_d         = StFetch;
         end
         default: state_d = StFetch;
      endcase
      ctl.pc_en = pc_write | (pc_write_cond & zero);
      ctl.state = state_q;
   end

   // Outputs are forced low combinationally while reset is asserted
   assign ctl_g = rst_n ? ctl : '0;

   assign mem_read    = ctl_g.mem_read;
   assign mem_write   = ctl_g.mem_write;
   assign i_or_d      = ctl_g.i_or_d;
   assign ir_write    = ctl_g.ir_write;
   assign pc_en       = ctl_g.pc_en;
   assign pc_source   = ctl_g.pc_source;
   assign alu_op      = ctl_g.alu_op;
   assign alu_src_a   = ctl_g.alu_src_a;
   assign alu_src_b   = ctl_g.alu_src_b;
   assign reg_write   = ctl_g.reg_write;
   assign reg_dst     = ctl_g.reg_dst;
   assign mem_to_reg  = ctl_g.mem_to_reg;
   assign epc_write   = ctl_g.epc_write;
   assign cause_write = ctl_g.cause_write;
   assign cause       = ctl_g.cause;
   assign instr_done  = ctl_g.instr_done;
   assign state       = ctl_g.state;

endmodule
